// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead
// slice per clock, linking nibbles through a registered carry.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // 4-bit lookahead slice: returns {c3, c2, sum}; c_i is the carry out of bit i.
    function automatic logic [5:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       ci
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic [3:0] sum;
        g    = x & y;
        p    = x | y;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & ci);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & ci);
        sum  = x ^ y ^ {c[2:0], ci};
        return {c[3], c[2], sum};
    endfunction

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [3:0]       nib_a_s;
    logic [3:0]       nib_b_s;
    logic [5:0]       slice_s;
    logic [3:0]       nib_sum_s;
    logic             c2_s;
    logic             c3_s;
    logic             last_s;

    // Select the active nibble of each latched operand and run it through the slice.
    always_comb begin
        nib_a_s   = a_r[{cnt_r, 2'b00} +: 4];
        nib_b_s   = b_r[{cnt_r, 2'b00} +: 4];
        slice_s   = cla4(nib_a_s, nib_b_s, carry_r);
        nib_sum_s = slice_s[3:0];
        c2_s      = slice_s[4];
        c3_s      = slice_s[5];
        last_s    = (cnt_r == LAST_NIB);
    end

    // Next-state decode for the accept / step / hand-off sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s == RUN) || (state_nx_s == DONE);
        end
    end

    // Operand capture, per-nibble accumulation and final carry/overflow capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                RUN: begin
                    s_r[{cnt_r, 2'b00} +: 4] <= nib_sum_s;
                    carry_r                  <= c3_s;
                    if (last_s) begin
                        cout_r <= c3_s;
                        ovf_r  <= c2_s ^ c3_s;
                        cnt_r  <= {CW{1'b0}};
                    end else begin
                        cnt_r  <= cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign s         = s_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized plus directed bench for nibble_serial_adder (WIDTH=16) checked
// against an arithmetic reference model and a per-cycle timing model.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {ovf, cout, s}
    function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                           input logic c, input logic sb);
        logic [15:0] yy;
        logic [16:0] t;
        logic        o;
        yy = sb ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {16'd0, c};
        o  = (x[15] == yy[15]) && (t[15] != x[15]);
        return {o, t[16], t[15:0]};
    endfunction

    // Timing/result model: idle -> NIB step edges -> done until out_ready
    bit          m_idle = 1'b1;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [15:0] m_s = 16'h0000;
    logic        m_cout = 1'b0;
    logic        m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [17:0] r;
        if (!rst_n) begin
            m_idle = 1'b1;
            m_done = 1'b0;
            m_left = 0;
        end else if (m_done) begin
            if (out_ready) begin
                m_done = 1'b0;
                m_idle = 1'b1;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (m_idle && in_valid) begin
            r      = ref_op(a, b, cin, sub);
            m_s    = r[15:0];
            m_cout = r[16];
            m_ovf  = r[17];
            m_idle = 1'b0;
            m_left = 4;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_idle});
        chk("busy", {31'd0, busy}, {31'd0, !m_idle});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
        if (m_done) begin
            chk("s", {16'd0, s}, {16'd0, m_s});
            chk("cout", {31'd0, cout}, {31'd0, m_cout});
            chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
        end
    end

    task automatic op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                      input logic ts, input int hold, input logic [15:0] es,
                      input logic ec, input logic eo);
        int cyc;
        @(posedge clk); #1;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, 32'd4);
        chk("s_lit", {16'd0, s}, {16'd0, es});
        chk("cout_lit", {31'd0, cout}, {31'd0, ec});
        chk("ovf_lit", {31'd0, ovf}, {31'd0, eo});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_s", {16'd0, s}, {16'd0, es});
            chk("hold_cout", {31'd0, cout}, {31'd0, ec});
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] r;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;
        rst_n = 1'b0;
        #23;
        chk("rst_s", {16'd0, s}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
        op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0);
        op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 16'h0002, 1'b1, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
        op(16'h8000, 16'h8000, 1'b0, 1'b0, 3, 16'h0000, 1'b1, 1'b1);

        // Abort mid-RUN: reset must clear outputs without a clock edge
        @(posedge clk); #1;
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_s", {16'd0, s}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 0, 16'h1010, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            r  = ref_op(ra, rb, rc, rs);
            op(ra, rb, rc, rs, int'($urandom_range(0, 3)), r[15:0], r[16], r[17]);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that feeds one 4-bit carry-lookahead slice per clock. The slice uses generate = a&b, propagate = a|b, and lookahead carries.
- A registered carry links consecutive nibbles.
- Sits between the operand source and the result consumer. Both sides use valid/ready handshakes.
- Lets the datapath reuse a single 4-bit CLA slice for wide operands.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of nibble steps per operation (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to nibble 0
- sub  input  1  1: compute a + ~b + cin; 0: compute a + b + cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum/difference
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow (carry into MSB xor carry out of MSB)
- busy  output  1  operation in progress (RUN or DONE)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset effect: state goes to IDLE. s=0, cout=0, ovf=0, out_valid=0, busy=0, carry register=0, nibble counter=0. in_ready=1 (it is decoded from IDLE).
- States:
  - IDLE: in_ready=1. When in_valid is high at a clk edge, latch a and b. If sub=1, latch ~b instead of b. Load the carry register with cin and clear the counter. Go to RUN.
  - RUN: in_ready=0, busy=1. Each cycle, nibble k = counter is computed from the latched a[4k+3:4k], latched b nibble and the carry register, using lookahead carries c0..c3. The sum nibble is written into s[4k+3:4k]. The carry register takes c3. The counter increments.
  - RUN, last step: when counter = NIB-1, cout takes c3 and ovf takes c2^c3 of that nibble. Go to DONE.
  - DONE: out_valid=1, busy=1, in_ready=0. s, cout and ovf are held stable. When out_ready is high at a clk edge, go to IDLE and drop out_valid.
- Latency: the accept edge is edge 0. out_valid is high in the cycle after edge NIB, which is 4 cycles for WIDTH=16.
- Throughput: one operation per NIB+2 cycles at best. No re-accept happens in the same cycle as the result handshake.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- While not out_valid, s holds partial results and is not checked. s is checked only while out_valid=1.
- Result arithmetic:
  - s = (a + b' + cin) mod 2^WIDTH, where b' = b or ~b according to sub.
  - cout is bit WIDTH of the exact sum.
  - For sub=1 with cin=1, cout=1 means no borrow.
- Reset mid-operation (RUN or DONE): the operation is aborted immediately. There is no residual result. The next accepted operation is computed from fresh operands.
- out_ready high in IDLE or RUN has no effect.

Test Plan (WIDTH=16):
- Plain add: a=0x1234, b=0x4321, cin=0, sub=0. Expect s=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0. Expect s=0x0000, cout=1, ovf=0. The carry crosses all four nibble boundaries.
- Subtract: a=0x0005, b=0x0007, cin=1, sub=1. Expect s=0xFFFE, cout=0 (borrow), ovf=0. Then a=0x0007, b=0x0005 gives s=0x0002, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001. Expect s=0x8000, ovf=1, cout=0. Then a=0x8000, b=0x8000 gives s=0x0000, ovf=1, cout=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE. out_valid, s, cout and ovf stay constant. in_ready=0, and a pulse on in_valid is ignored.
  - Then raise out_ready. The next cycle shows out_valid=0 and in_ready=1.
- Reset mid-RUN: drive rst_n=0 after 2 RUN cycles of a=0xAAAA, b=0x5555.
  - Outputs are 0 and in_ready=1 without waiting for a clock edge.
  - After release, a=0x0F0F, b=0x0101 gives s=0x1010, cout=0.
